// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources
// Optional feature macro: UART_ARB_BURST_EN (keep the grant across a burst until a byte with req_last completes)
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_par_en,
  input  logic [NUM_REQ-1:0]            req_par_typ,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_data_valid,
  output logic                          tx_par_en,
  output logic                          tx_par_typ,
  input  logic                          tx_busy,
  output logic                          err_timeout
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       win;
  logic [7:0]          cnt;
  logic [IW:0]         pos;
  logic [IW-1:0]       rr_sel;
  logic [IW-1:0]       cap_idx;
  logic [NUM_REQ-1:0]  cap_oh;
  logic                cap_go;
  logic                burst_go;

  // Round-robin search: first valid requester strictly after ptr, wrapping modulo NUM_REQ
  always_comb begin
    rr_sel = ptr;
    pos    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_REQ)) pos = pos - (IW+1)'(NUM_REQ);
      if (req_valid[pos[IW-1:0]]) rr_sel = pos[IW-1:0];
    end
  end

`ifdef UART_ARB_BURST_EN
  logic last_q;
  // A burst continues straight into the next capture for the same owner when busy falls
  assign burst_go = (state == WAIT_DONE) && !tx_busy && !last_q && req_valid[win];
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign burst_go    = 1'b0;
`endif

  assign cap_go  = ((state == IDLE) && (|req_valid) && !tx_busy) || burst_go;
  assign cap_idx = burst_go ? win : rr_sel;
  assign cap_oh  = NUM_REQ'(1) << cap_idx;

  // Frame sequencer: capture winner, strobe, wait for busy to rise, then wait for it to fall
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      ptr           <= IW'(NUM_REQ - 1);
      win           <= '0;
      cnt           <= '0;
      grant         <= '0;
      req_ready     <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= 1'b0;
      err_timeout   <= 1'b0;
`ifdef UART_ARB_BURST_EN
      last_q        <= 1'b0;
`endif
    end else begin
      tx_data_valid <= 1'b0;
      req_ready     <= '0;
      err_timeout   <= 1'b0;
      if (cap_go) begin
        // Outputs registered here are presented during LOAD and held until the next capture
        win           <= cap_idx;
        grant         <= cap_oh;
        req_ready     <= cap_oh;
        tx_data_valid <= 1'b1;
        tx_p_data     <= req_data[cap_idx*DATA_WIDTH +: DATA_WIDTH];
        tx_par_en     <= req_par_en[cap_idx];
        tx_par_typ    <= req_par_typ[cap_idx];
`ifdef UART_ARB_BURST_EN
        last_q        <= req_last[cap_idx];
`endif
        state         <= LOAD;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            cnt   <= '0;
            state <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (tx_busy) begin
              state <= WAIT_DONE;
            end else begin
              cnt <= cnt + 8'd1;
              // The byte counts as consumed; the owner already saw req_ready
              if (cnt + 8'd1 == TO_LAST) begin
                err_timeout <= 1'b1;
                grant       <= '0;
                ptr         <= win;
                state       <= IDLE;
              end
            end
          end
          WAIT_DONE: begin
            if (!tx_busy) begin
              ptr   <= win;
              grant <= '0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources.
- Accepts one byte per grant from each requester.
- Drives the transmitter's parallel data, data-valid strobe and per-frame parity configuration.
- Sequences each frame using the transmitter's busy flag.
- Sits between on-chip byte producers and the UART TX; in loopback benches, the UART RX sits on the serial side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, frame data width
BUSY_TIMEOUT, 16, max CLK cycles to wait for tx_busy to rise after a strobe (2..255)

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester byte available; held until matching req_ready
req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_par_en  input  NUM_REQ  per-requester parity enable
req_par_typ  input  NUM_REQ  per-requester parity type (0 even, 1 odd)
req_last  input  NUM_REQ  per-requester end-of-burst marker (used only with UART_ARB_BURST_EN)
req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
grant  output  NUM_REQ  one-hot owner of the current frame; 0 when idle
tx_p_data  output  DATA_WIDTH  data to the transmitter
tx_data_valid  output  1  one-cycle load strobe to the transmitter
tx_par_en  output  1  parity enable to the transmitter
tx_par_typ  output  1  parity type to the transmitter
tx_busy  input  1  transmitter busy flag
err_timeout  output  1  one-cycle pulse: tx_busy never rose within BUSY_TIMEOUT

Behaviour:
- Reset: RST high at a CLK edge forces the following state:
  - All outputs 0; FSM to IDLE; timeout counter 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame aborts the frame; no req_ready is issued for it.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Acts when |req_valid and tx_busy==0.
  - Winner = first set bit searching from ptr+1 upward, modulo NUM_REQ.
  - Registers winner's data, par_en and par_typ into tx_p_data, tx_par_en, tx_par_typ.
  - Sets grant one-hot; goes to LOAD.
  - If tx_busy==1, stays in IDLE with no grant.
- LOAD (exactly 1 cycle):
  - tx_data_valid=1 and req_ready[winner]=1.
  - Goes to WAIT_BUSY; counter cleared.
  - Latency: req_valid sampled in IDLE → tx_data_valid and req_ready on the next cycle.
- WAIT_BUSY:
  - tx_busy==1 → WAIT_DONE.
  - Otherwise counter increments; on reaching BUSY_TIMEOUT-1: err_timeout=1 for 1 cycle, grant cleared, ptr←winner, go to IDLE.
  - The byte is treated as consumed; req_ready was already given.
- WAIT_DONE:
  - Holds grant; waits for tx_busy==0.
  - Then ptr←winner, grant←0, go to IDLE.
  - At least one IDLE cycle separates frames.
- Output stability:
  - tx_p_data, tx_par_en and tx_par_typ stay stable from LOAD until the next IDLE selection.
  - Between frames they hold their last value; configuration never changes while tx_busy=1.
- Requester rules:
  - Dropping req_valid before req_ready is legal; that requester is skipped from the next arbitration.
  - A req_valid change during LOAD/WAIT_* is ignored until IDLE.
- Fairness: a requester held continuously valid waits at most NUM_REQ-1 frames.
- Counter width: 8 bits; the wrap is unreachable given the parameter limit.

Optional Feature:
UART_ARB_BURST_EN
- With the macro:
  - When WAIT_DONE exits and the captured req_last==0 and req_valid[winner]==1, the FSM goes directly to the IDLE-equivalent capture for the same winner.
  - ptr does not advance and grant stays set; other requesters are locked out until a frame with req_last=1 completes.
  - A timeout always ends the burst.
- Without the macro: req_last is ignored; every frame re-arbitrates.

Test Plan:
1. Single byte: req_valid=0001, data0=8'hBB, par_en=1, typ=1, tx_busy rises 2 cycles after the strobe and lasts 40 cycles → one tx_data_valid with tx_p_data=BB, par_en=1, typ=1; req_ready=0001 the same cycle; grant clears when busy falls.
2. All four requesters valid continuously, 3 frames each (data 8'h10+i) → frame order 0,1,2,3,0,1,2,3,…; each req_ready pulse pairs with the matching tx_p_data.
3. Per-frame configuration: req0 (en=1, typ=0, 8'h8D) and req1 (en=0, 8'h9F) → tx_par_en=1 then 0; values unchanged while tx_busy=1.
4. Timeout: tx_busy tied 0 after a strobe from req2 → err_timeout pulses exactly BUSY_TIMEOUT cycles after LOAD; next grant goes to req3 if valid.
5. Reset mid-frame: assert RST in WAIT_DONE → next cycle all outputs 0; with req0 and req3 valid afterwards, req0 is granted first.
6. Burst (macro on): req1 sends 3 bytes with req_last=0,0,1 while req0 is valid → req1 bytes are sent back to back, then req0; with the macro off → order 1,0,1,…
